poly_voice_mixer: RTL and testbench
===================================

POLY_VOICE_MIXER -- requirements
Module: poly_voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, number of mixed voices (>=2).
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, signed per-voice sample width.
REQ-003 SHALL have parameter GAIN_WIDTH, default 8, unsigned per-voice gain width (gain/2^GAIN_WIDTH).
REQ-004 SHALL have parameter OUT_WIDTH, default 16, signed mixed output width.
REQ-005 SHALL have port clk_in, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port sample_trig_in, input, 1, one-cycle pulse requesting one mix frame.
REQ-008 SHALL have port voice_on_in, input, NUM_VOICES, per-voice enable.
REQ-009 SHALL have port voice_samples_in, input, NUM_VOICES x SAMPLE_WIDTH, signed voice samples.
REQ-010 SHALL have port voice_gain_in, input, NUM_VOICES x GAIN_WIDTH, unsigned voice gains.
REQ-011 SHALL have port master_shift_in, input, $clog2(NUM_VOICES)+1, extra arithmetic right shift.
REQ-012 SHALL have port mix_out, output, OUT_WIDTH, signed mixed sample.
REQ-013 SHALL have port mix_valid_out, output, 1, mix_out holds a new frame.
REQ-014 SHALL have port mix_ready_in, input, 1, consumer accepts frame when high with mix_valid_out.
REQ-015 SHALL have port active_count_out, output, $clog2(NUM_VOICES+1), enabled voices in current frame.
REQ-016 SHALL have port busy_out, output, 1, high in any state but IDLE.
REQ-017 SHALL have port overrun_out, output, 1, sticky: a trigger was dropped.
REQ-018 SHALL have port clip_out, output, 1, last frame clipped.

Function
REQ-019 SHALL implement states IDLE, ACCUM, OUTPUT, HOLD.
REQ-020 IDLE + sample_trig_in: SHALL snapshot voice_on_in, voice_samples_in, voice_gain_in, master_shift_in, clear accumulator, set index 0, enter ACCUM.
REQ-021 ACCUM: SHALL add snapshot sample[idx] x {0,gain[idx]} (signed product, SAMPLE_WIDTH+GAIN_WIDTH+1 bits) to accumulator if on[idx], else add 0; one voice per cycle.
REQ-022 Accumulator SHALL be SAMPLE_WIDTH+GAIN_WIDTH+$clog2(NUM_VOICES)+1 bits signed; no internal overflow possible.
REQ-023 After idx = NUM_VOICES-1 SHALL enter OUTPUT; index SHALL not wrap within a frame.
REQ-024 OUTPUT: SHALL compute acc >>> (GAIN_WIDTH + master_shift), reduce to OUT_WIDTH per REQ-033/034, register to mix_out, assert mix_valid_out, enter HOLD.
REQ-025 Latency: trigger at cycle 0 SHALL give mix_valid_out high at cycle NUM_VOICES+2.
REQ-026 HOLD: mix_out and mix_valid_out SHALL stay stable while mix_ready_in low.
REQ-027 HOLD + mix_ready_in: SHALL deassert mix_valid_out next cycle and enter IDLE; if sample_trig_in same cycle, SHALL accept it (snapshot, enter ACCUM).
REQ-028 sample_trig_in in ACCUM, OUTPUT, or HOLD without mix_ready_in: SHALL be ignored and set overrun_out.
REQ-029 active_count_out SHALL equal popcount of snapshot voice_on, updated on snapshot.
REQ-030 mix_out SHALL retain last value after handshake until next OUTPUT.

Reset
REQ-031 rst_in SHALL asynchronously force IDLE, accumulator 0, mix_out 0, mix_valid_out 0, active_count_out 0, busy_out 0, overrun_out 0, clip_out 0.
REQ-032 Reset mid-frame SHALL discard the frame; no mix_valid_out for it.

Configuration
REQ-033 With MIXER_SATURATE_EN defined: out-of-range result SHALL clamp to +2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1); clip_out SHALL be set at OUTPUT if clamped, else cleared.
REQ-034 Without MIXER_SATURATE_EN: result SHALL truncate to low OUT_WIDTH bits (wrap); clip_out SHALL be constant 0.

Verification (defaults)
REQ-035 Voice0 on, sample 1000, gain 255, shift 0, others off -> mix_out 996, active_count 1, valid at cycle 10.
REQ-036 All 8 on, sample 32767, gain 255, shift 0 -> saturate build: mix_out 32767, clip_out 1; wrap build: mix_out -1032, clip_out 0.
REQ-037 All 8 on, sample -32768, gain 255, shift 3 -> mix_out -32640, clip_out 0.
REQ-038 mix_ready_in low 5 cycles after valid, second trigger during HOLD -> mix_out stable, overrun_out 1, no extra frame; trigger with ready high -> new frame, valid 10 cycles later.
REQ-039 rst_in pulsed at idx 3 of ACCUM -> all outputs 0 immediately; following trigger with REQ-035 stimulus -> 996.
REQ-040 voice_on_in all 0, gains 255 -> mix_out 0, active_count 0, clip_out 0.

Source files
------------

// File: rtl/poly_voice_mixer.sv
// Polyphonic voice mixer: per-frame snapshot of voices, serial gain multiply-accumulate, scaled output handshake.
// Optional MIXER_SATURATE_EN clamps the output (and reports clip_out); default build wraps to OUT_WIDTH bits.
module poly_voice_mixer #(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int GAIN_WIDTH   = 8,
    parameter int OUT_WIDTH    = 16
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 sample_trig_in,
    input  logic [NUM_VOICES-1:0]                voice_on_in,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   voice_samples_in,
    input  logic [NUM_VOICES*GAIN_WIDTH-1:0]     voice_gain_in,
    input  logic [$clog2(NUM_VOICES):0]          master_shift_in,
    output logic signed [OUT_WIDTH-1:0]          mix_out,
    output logic                                 mix_valid_out,
    input  logic                                 mix_ready_in,
    output logic [$clog2(NUM_VOICES+1)-1:0]      active_count_out,
    output logic                                 busy_out,
    output logic                                 overrun_out,
    output logic                                 clip_out
);

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int SH_W   = IDX_W + 1;
    localparam int CNT_W  = $clog2(NUM_VOICES + 1);
    localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;
    localparam int ACC_W  = SAMPLE_WIDTH + GAIN_WIDTH + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                            state_q;
    logic [NUM_VOICES-1:0]             on_q;
    logic [NUM_VOICES*SAMPLE_WIDTH-1:0] samples_q;
    logic [NUM_VOICES*GAIN_WIDTH-1:0]  gain_q;
    logic [SH_W-1:0]                   shift_q;
    logic signed [ACC_W-1:0]           acc_q;
    logic [IDX_W-1:0]                  idx_q;
    logic signed [OUT_WIDTH-1:0]       mix_q;
    logic                              valid_q;
    logic [CNT_W-1:0]                  count_q;
    logic                              overrun_q;

    logic signed [PROD_W-1:0]          sample_ext;
    logic signed [PROD_W-1:0]          gain_ext;
    logic signed [PROD_W-1:0]          product;
    logic signed [ACC_W-1:0]           addend;
    logic signed [ACC_W-1:0]           acc_d;
    logic signed [ACC_W-1:0]           shifted;
    logic signed [OUT_WIDTH-1:0]       mix_d;
    logic [CNT_W-1:0]                  count_d;
    logic                              clip_d;

    // One multiply per cycle: the gain is zero-extended so the product is always signed-correct.
    always_comb begin
        sample_ext = PROD_W'($signed(samples_q[int'(idx_q)*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
        gain_ext   = PROD_W'({1'b0, gain_q[int'(idx_q)*GAIN_WIDTH +: GAIN_WIDTH]});
        product    = sample_ext * gain_ext;
        addend     = on_q[idx_q] ? ACC_W'(product) : '0;
        acc_d      = acc_q + addend;
    end

`ifdef MIXER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_WIDTH - 1)));

    always_comb begin
        shifted = acc_q >>> (GAIN_WIDTH + int'(shift_q));
        clip_d  = 1'b0;
        mix_d   = OUT_WIDTH'(shifted);
        if (shifted > SAT_MAX) begin
            mix_d  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            clip_d = 1'b1;
        end else if (shifted < SAT_MIN) begin
            mix_d  = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            clip_d = 1'b1;
        end
    end
`else
    always_comb begin
        shifted = acc_q >>> (GAIN_WIDTH + int'(shift_q));
        mix_d   = OUT_WIDTH'(shifted);
        clip_d  = 1'b0;
    end
`endif

    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            count_d = count_d + CNT_W'(voice_on_in[i]);
        end
    end

    // Frame sequencer. A trigger is only honoured from IDLE or in the same cycle a HOLD frame is consumed.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            on_q      <= '0;
            samples_q <= '0;
            gain_q    <= '0;
            shift_q   <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            mix_q     <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_trig_in) begin
                        on_q      <= voice_on_in;
                        samples_q <= voice_samples_in;
                        gain_q    <= voice_gain_in;
                        shift_q   <= master_shift_in;
                        count_q   <= count_d;
                        acc_q     <= '0;
                        idx_q     <= '0;
                        state_q   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (sample_trig_in) overrun_q <= 1'b1;
                    acc_q <= acc_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= OUTPUT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (sample_trig_in) overrun_q <= 1'b1;
                    mix_q   <= mix_d;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (mix_ready_in) begin
                        valid_q <= 1'b0;
                        if (sample_trig_in) begin
                            on_q      <= voice_on_in;
                            samples_q <= voice_samples_in;
                            gain_q    <= voice_gain_in;
                            shift_q   <= master_shift_in;
                            count_q   <= count_d;
                            acc_q     <= '0;
                            idx_q     <= '0;
                            state_q   <= ACCUM;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (sample_trig_in) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MIXER_SATURATE_EN
    logic clip_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clip_q <= 1'b0;
        end else if (state_q == OUTPUT) begin
            clip_q <= clip_d;
        end
    end

    assign clip_out = clip_q;
`else
    assign clip_out = clip_d;
`endif

    assign mix_out          = mix_q;
    assign mix_valid_out    = valid_q;
    assign active_count_out = count_q;
    assign busy_out         = (state_q != IDLE);
    assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed testbench for poly_voice_mixer at default parameters; expected values are hand-computed.
// Expectations for the clipping frame follow whether MIXER_SATURATE_EN is defined.
module tb_poly_voice_mixer;

    logic               clk;
    logic               rst;
    logic               sample_trig_in;
    logic [7:0]         voice_on_in;
    logic [127:0]       voice_samples_in;
    logic [63:0]        voice_gain_in;
    logic [3:0]         master_shift_in;
    logic signed [15:0] mix_out;
    logic               mix_valid_out;
    logic               mix_ready_in;
    logic [3:0]         active_count_out;
    logic               busy_out;
    logic               overrun_out;
    logic               clip_out;

    int errors = 0;
    int checks = 0;

`ifdef MIXER_SATURATE_EN
    localparam int EXP_FULL_MIX  = 32767;
    localparam int EXP_FULL_CLIP = 1;
`else
    localparam int EXP_FULL_MIX  = -1032;
    localparam int EXP_FULL_CLIP = 0;
`endif

    poly_voice_mixer #(
        .NUM_VOICES   (8),
        .SAMPLE_WIDTH (16),
        .GAIN_WIDTH   (8),
        .OUT_WIDTH    (16)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .sample_trig_in   (sample_trig_in),
        .voice_on_in      (voice_on_in),
        .voice_samples_in (voice_samples_in),
        .voice_gain_in    (voice_gain_in),
        .master_shift_in  (master_shift_in),
        .mix_out          (mix_out),
        .mix_valid_out    (mix_valid_out),
        .mix_ready_in     (mix_ready_in),
        .active_count_out (active_count_out),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out),
        .clip_out         (clip_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every voice gets the same sample and gain; voice_on decides which ones count.
    task automatic applyStimulus(input logic [7:0] on, input logic signed [15:0] smp,
                                 input logic [7:0] gain, input logic [3:0] shift);
        voice_on_in = on;
        for (int i = 0; i < 8; i++) begin
            voice_samples_in[i*16 +: 16] = smp;
            voice_gain_in[i*8 +: 8]      = gain;
        end
        master_shift_in = shift;
    endtask

    // Pulse the trigger (optionally together with ready) and check the exact NUM_VOICES+2 latency.
    task automatic triggerAndWait(input string tag, input logic withReady);
        sample_trig_in = 1'b1;
        mix_ready_in   = withReady;
        step();
        sample_trig_in = 1'b0;
        mix_ready_in   = 1'b0;
        checkOutput({tag, " busy after trigger"}, busy_out, 1);
        checkOutput({tag, " valid low after trigger"}, mix_valid_out, 0);
        repeat (8) step();
        checkOutput({tag, " valid still low at cycle 9"}, mix_valid_out, 0);
        step();
        checkOutput({tag, " valid at cycle 10"}, mix_valid_out, 1);
    endtask

    task automatic handshake(input string tag, input int expMix);
        mix_ready_in = 1'b1;
        step();
        mix_ready_in = 1'b0;
        checkOutput({tag, " valid dropped"}, mix_valid_out, 0);
        checkOutput({tag, " idle"}, busy_out, 0);
        checkOutput({tag, " mix retained"}, mix_out, expMix);
    endtask

    initial begin
        rst              = 1'b1;
        sample_trig_in   = 1'b0;
        mix_ready_in     = 1'b0;
        voice_on_in      = '0;
        voice_samples_in = '0;
        voice_gain_in    = '0;
        master_shift_in  = '0;
        step();
        step();
        checkOutput("reset mix", mix_out, 0);
        checkOutput("reset valid", mix_valid_out, 0);
        checkOutput("reset count", active_count_out, 0);
        checkOutput("reset busy", busy_out, 0);
        checkOutput("reset overrun", overrun_out, 0);
        checkOutput("reset clip", clip_out, 0);
        rst = 1'b0;
        step();

        $display("[TB] single voice: 1000*255>>8");
        applyStimulus(8'b0000_0001, 16'sd1000, 8'd255, 4'd0);
        triggerAndWait("single", 1'b0);
        checkOutput("single mix", mix_out, 996);
        checkOutput("single count", active_count_out, 1);
        checkOutput("single clip", clip_out, 0);
        handshake("single", 996);

        $display("[TB] all voices full scale positive");
        applyStimulus(8'hFF, 16'sd32767, 8'd255, 4'd0);
        triggerAndWait("fullpos", 1'b0);
        checkOutput("fullpos mix", mix_out, EXP_FULL_MIX);
        checkOutput("fullpos clip", clip_out, EXP_FULL_CLIP);
        checkOutput("fullpos count", active_count_out, 8);
        handshake("fullpos", EXP_FULL_MIX);

        $display("[TB] all voices full scale negative with shift 3");
        applyStimulus(8'hFF, -16'sd32768, 8'd255, 4'd3);
        triggerAndWait("fullneg", 1'b0);
        checkOutput("fullneg mix", mix_out, -32640);
        checkOutput("fullneg clip", clip_out, 0);
        handshake("fullneg", -32640);

        $display("[TB] all voices off");
        applyStimulus(8'h00, 16'sd12345, 8'd255, 4'd0);
        triggerAndWait("alloff", 1'b0);
        checkOutput("alloff mix", mix_out, 0);
        checkOutput("alloff count", active_count_out, 0);
        checkOutput("alloff clip", clip_out, 0);
        handshake("alloff", 0);

        $display("[TB] back-pressure with dropped trigger");
        applyStimulus(8'b0000_0001, 16'sd1000, 8'd255, 4'd0);
        triggerAndWait("hold", 1'b0);
        applyStimulus(8'hFF, 16'sd7777, 8'd200, 4'd0);
        step();
        step();
        sample_trig_in = 1'b1;
        step();
        sample_trig_in = 1'b0;
        step();
        step();
        checkOutput("hold mix stable", mix_out, 996);
        checkOutput("hold valid stable", mix_valid_out, 1);
        checkOutput("hold busy", busy_out, 1);
        checkOutput("hold overrun", overrun_out, 1);
        checkOutput("hold count unchanged", active_count_out, 1);
        // -2000*128 = -256000, shifted by 8+1 gives exactly -500
        applyStimulus(8'b0000_0010, -16'sd2000, 8'd128, 4'd1);
        triggerAndWait("chained", 1'b1);
        checkOutput("chained mix", mix_out, -500);
        checkOutput("chained count", active_count_out, 1);
        checkOutput("chained overrun sticky", overrun_out, 1);
        handshake("chained", -500);

        $display("[TB] reset in the middle of accumulation");
        applyStimulus(8'hFF, 16'sd5000, 8'd100, 4'd0);
        sample_trig_in = 1'b1;
        step();
        sample_trig_in = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        checkOutput("midreset mix", mix_out, 0);
        checkOutput("midreset valid", mix_valid_out, 0);
        checkOutput("midreset count", active_count_out, 0);
        checkOutput("midreset busy", busy_out, 0);
        checkOutput("midreset overrun", overrun_out, 0);
        checkOutput("midreset clip", clip_out, 0);
        #2;
        rst = 1'b0;
        repeat (12) step();
        checkOutput("midreset no frame", mix_valid_out, 0);
        checkOutput("midreset still idle", busy_out, 0);

        applyStimulus(8'b0000_0001, 16'sd1000, 8'd255, 4'd0);
        triggerAndWait("postreset", 1'b0);
        checkOutput("postreset mix", mix_out, 996);
        checkOutput("postreset count", active_count_out, 1);
        handshake("postreset", 996);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
